// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button / switch debouncer.
package debounce_pkg;

   // Filter FSM states: two settled levels and two qualification windows.
   typedef enum logic [1:0] {
      ST_LO   = 2'd0,
      WAIT_HI = 2'd1,
      ST_HI   = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   // Synchronized samples a new level must hold before it is accepted.
   localparam int DEFAULT_STABLE_CYCLES = 32'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing any asynchronous level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_d, s1_q;
   logic s2_d, s2_q;

   // Next values: shift the raw input through the two stages.
   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   // Synchronizer stages, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/debouncer.sv
// Debouncer: synchronizes a raw button line and accepts a new level only after
// it has been seen on STABLE_CYCLES+1 consecutive synchronized samples. The
// settled level and one-cycle rise/fall strobes are all driven from flops.
module debouncer
   import debounce_pkg::*;
#(
   parameter  int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   localparam int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic q,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             btn_sync;
   state_t           state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             q_d, q_q;
   logic             rise_d, rise_q;
   logic             fall_d, fall_q;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn),
      .q   (btn_sync)
   );

   // Next-state logic: strobes default low; any mismatching sample during a
   // window aborts it, and the counter is cleared whenever a window is left.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         ST_LO: begin
            cnt_d = '0;
            if (btn_sync) begin
               state_d = WAIT_HI;
            end else begin
               state_d = ST_LO;
            end
         end
         WAIT_HI: begin
            if (!btn_sync) begin
               state_d = ST_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HI;
               cnt_d   = '0;
               q_d     = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HI: begin
            cnt_d = '0;
            if (!btn_sync) begin
               state_d = WAIT_LO;
            end else begin
               state_d = ST_HI;
            end
         end
         WAIT_LO: begin
            if (btn_sync) begin
               state_d = ST_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LO;
               cnt_d   = '0;
               q_d     = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LO;
            cnt_d   = '0;
            q_d     = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LO;
         cnt_q   <= '0;
         q_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign q    = q_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: three instances (STABLE_CYCLES 4, 2, 255) share clk,
// rst and btn. A run-length model says a level is accepted once the
// synchronized input has differed from the current output on STABLE_CYCLES+1
// consecutive edges.
module tb_debouncer;

   localparam int NI = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          btn;
   wire  [NI-1:0] q_o;
   wire  [NI-1:0] rise_o;
   wire  [NI-1:0] fall_o;

   int total = 0;
   int bad   = 0;

   int sv [NI] = '{4, 2, 255};
   bit b1 [NI];
   bit b2 [NI];
   bit mq [NI];
   bit mr [NI];
   bit mf [NI];
   int run[NI];

   always #5 clk = ~clk;

   debouncer #(.STABLE_CYCLES(4)) u_d4 (
      .clk(clk), .rst(rst), .btn(btn), .q(q_o[0]), .rise(rise_o[0]), .fall(fall_o[0]));
   debouncer #(.STABLE_CYCLES(2)) u_d2 (
      .clk(clk), .rst(rst), .btn(btn), .q(q_o[1]), .rise(rise_o[1]), .fall(fall_o[1]));
   debouncer #(.STABLE_CYCLES(255)) u_d255 (
      .clk(clk), .rst(rst), .btn(btn), .q(q_o[2]), .rise(rise_o[2]), .fall(fall_o[2]));

   task automatic model_clear;
      for (int i = 0; i < NI; i++) begin
         b1[i] = 1'b0; b2[i] = 1'b0; mq[i] = 1'b0;
         mr[i] = 1'b0; mf[i] = 1'b0; run[i] = 0;
      end
   endtask

   // Advance one clock edge, update the model, then settle 1 time unit.
   task automatic tick;
      bit s2v;
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
         mr[i] = 1'b0;
         mf[i] = 1'b0;
         if (!rst) begin
            s2v   = b2[i];
            b2[i] = b1[i];
            b1[i] = btn;
            if (s2v != mq[i]) begin
               run[i]++;
               if (run[i] == sv[i] + 1) begin
                  mq[i]  = s2v;
                  run[i] = 0;
                  mr[i]  = s2v;
                  mf[i]  = !s2v;
               end
            end else begin
               run[i] = 0;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      btn = 1'b0;
      model_clear();
      #1;
      total++;
      if ({q_o, rise_o, fall_o} !== 9'b0) begin
         bad++;
         $display("FAIL reset_async: got %b want 0", {q_o, rise_o, fall_o});
      end
      tick(); tick();
      rst = 1'b0;
      for (int n = 0; n < 20; n++) begin
         tick();
         total++;
         if ({q_o, rise_o, fall_o} !== 9'b0) begin
            bad++;
            $display("FAIL idle_low cyc=%0d: got %b want 0", n, {q_o, rise_o, fall_o});
         end
      end
   endtask

   task automatic test_clean_press;
      int first = -1;
      int nrise = 0;
      btn = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         tick();
         total++;
         if ({q_o[0], rise_o[0], fall_o[0]} !== {mq[0], mr[0], mf[0]}) begin
            bad++;
            $display("FAIL clean_press edge=%0d: got %b want %b", n,
                     {q_o[0], rise_o[0], fall_o[0]}, {mq[0], mr[0], mf[0]});
         end
         if (rise_o[0]) begin
            nrise++;
            if (first < 0) first = n - 1;
         end
      end
      total++;
      if (first != 6 || nrise != 1) begin
         bad++;
         $display("FAIL clean_press_latency: got lat=%0d count=%0d want lat=6 count=1", first, nrise);
      end
   endtask

   task automatic test_release_glitch;
      int first = -1;
      int nfall = 0;
      btn = 1'b0;
      repeat (3) begin
         tick();
         total++;
         if (q_o[0] !== 1'b1 || fall_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL release_glitch: got q=%b fall=%b want q=1 fall=0", q_o[0], fall_o[0]);
         end
      end
      btn = 1'b1;
      repeat (10) begin
         tick();
         total++;
         if (q_o[0] !== 1'b1 || fall_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL release_glitch_recover: got q=%b fall=%b want q=1 fall=0", q_o[0], fall_o[0]);
         end
      end
      btn = 1'b0;
      for (int n = 1; n <= 15; n++) begin
         tick();
         total++;
         if ({q_o[0], rise_o[0], fall_o[0]} !== {mq[0], mr[0], mf[0]}) begin
            bad++;
            $display("FAIL release edge=%0d: got %b want %b", n,
                     {q_o[0], rise_o[0], fall_o[0]}, {mq[0], mr[0], mf[0]});
         end
         if (fall_o[0]) begin
            nfall++;
            if (first < 0) first = n - 1;
         end
      end
      total++;
      if (first != 6 || nfall != 1) begin
         bad++;
         $display("FAIL release_latency: got lat=%0d count=%0d want lat=6 count=1", first, nfall);
      end
   endtask

   task automatic test_bounce;
      logic [3:0] pat = 4'b0101;
      int first = -1;
      int nrise = 0;
      for (int k = 0; k < 4; k++) begin
         btn = pat[k];
         tick();
         total++;
         if (q_o[0] !== 1'b0 || rise_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL bounce_early: got q=%b rise=%b want 0 0", q_o[0], rise_o[0]);
         end
         if (rise_o[0]) nrise++;
      end
      btn = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         tick();
         total++;
         if ({q_o[0], rise_o[0], fall_o[0]} !== {mq[0], mr[0], mf[0]}) begin
            bad++;
            $display("FAIL bounce edge=%0d: got %b want %b", n,
                     {q_o[0], rise_o[0], fall_o[0]}, {mq[0], mr[0], mf[0]});
         end
         if (rise_o[0]) begin
            nrise++;
            if (first < 0) first = n - 1;
         end
      end
      total++;
      if (first != 6 || nrise != 1) begin
         bad++;
         $display("FAIL bounce_latency: got lat=%0d count=%0d want lat=6 count=1", first, nrise);
      end
   endtask

   task automatic test_reset_mid_wait;
      int first[NI];
      rst = 1'b1;
      btn = 1'b0;
      model_clear();
      tick();
      rst = 1'b0;
      repeat (4) tick();
      btn = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      model_clear();
      #1;
      total++;
      if ({q_o, rise_o, fall_o} !== 9'b0) begin
         bad++;
         $display("FAIL reset_mid_wait: got %b want 0", {q_o, rise_o, fall_o});
      end
      repeat (3) begin
         tick();
         total++;
         if ({q_o, rise_o, fall_o} !== 9'b0) begin
            bad++;
            $display("FAIL reset_held: got %b want 0", {q_o, rise_o, fall_o});
         end
      end
      rst = 1'b0;
      for (int i = 0; i < NI; i++) first[i] = -1;
      for (int n = 1; n <= 300; n++) begin
         tick();
         for (int i = 0; i < NI; i++) begin
            if (rise_o[i] && first[i] < 0) first[i] = n - 1;
         end
      end
      for (int i = 0; i < NI; i++) begin
         total++;
         if (first[i] != sv[i] + 2) begin
            bad++;
            $display("FAIL post_reset_rise inst=%0d: got lat=%0d want %0d", i, first[i], sv[i] + 2);
         end
      end
   endtask

   task automatic test_param_sweep;
      int lat[NI];
      int cnt[NI];
      for (int pass = 0; pass < 2; pass++) begin
         btn = (pass == 0) ? 1'b0 : 1'b1;
         for (int i = 0; i < NI; i++) begin lat[i] = -1; cnt[i] = 0; end
         for (int n = 1; n <= 300; n++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
               if (rise_o[i] || fall_o[i]) begin
                  cnt[i]++;
                  if (lat[i] < 0) lat[i] = n - 1;
               end
               total++;
               if ({q_o[i], rise_o[i], fall_o[i]} !== {mq[i], mr[i], mf[i]}) begin
                  bad++;
                  $display("FAIL sweep inst=%0d edge=%0d: got %b want %b", i, n,
                           {q_o[i], rise_o[i], fall_o[i]}, {mq[i], mr[i], mf[i]});
               end
            end
         end
         for (int i = 0; i < NI; i++) begin
            total++;
            if (lat[i] != sv[i] + 2 || cnt[i] != 1) begin
               bad++;
               $display("FAIL sweep_latency inst=%0d pass=%0d: got lat=%0d count=%0d want lat=%0d count=1",
                        i, pass, lat[i], cnt[i], sv[i] + 2);
            end
         end
      end
   endtask

   task automatic test_random;
      int hold;
      int cyc = 0;
      while (cyc < 4000) begin
         btn  = 1'($urandom_range(0, 1));
         hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 300))
                                            : int'($urandom_range(1, 8));
         repeat (hold) begin
            tick();
            cyc++;
            for (int i = 0; i < NI; i++) begin
               total++;
               if ({q_o[i], rise_o[i], fall_o[i]} !== {mq[i], mr[i], mf[i]}) begin
                  bad++;
                  $display("FAIL random inst=%0d cyc=%0d: got %b want %b", i, cyc,
                           {q_o[i], rise_o[i], fall_o[i]}, {mq[i], mr[i], mf[i]});
               end
            end
            total++;
            if ((rise_o & fall_o) !== 3'b000) begin
               bad++;
               $display("FAIL strobe_exclusive cyc=%0d: got %b want 000", cyc, rise_o & fall_o);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      btn = 1'b0;
      test_reset();
      test_clean_press();
      test_release_glitch();
      test_bounce();
      test_reset_mid_wait();
      test_param_sweep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
